// File: rtl/hold_grab_detector.sv
// Hand-to-hold hit search: scans the hold table one entry per clock
// and reports the lowest-index valid hold whose rectangle contains the hand.
module hold_grab_detector #(
    parameter int NUM_HOLDS = 16,
    parameter int IDX_W     = 4,
    parameter int HOLD_W    = 32,
    parameter int HOLD_H    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [12:0]      hand_x,
    input  logic [12:0]      hand_y,
    output logic [IDX_W-1:0] hold_addr,
    input  logic [12:0]      hold_x,
    input  logic [12:0]      hold_y,
    input  logic             hold_valid,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SCAN  = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_HOLDS - 1);
    localparam logic [13:0]      W_EXT = 14'(HOLD_W);
    localparam logic [13:0]      H_EXT = 14'(HOLD_H);

    state_e           state_q, state_d;
    logic [12:0]      hx_q, hx_d;
    logic [12:0]      hy_q, hy_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [13:0]      hx_e, hy_e;
    logic [13:0]      lx_e, ty_e;
    logic [13:0]      rx_e, by_e;
    logic             match;
    logic [IDX_W-1:0] addr_inc;

    // Containment test at 14 bits so holds near the world edge never wrap.
    always_comb begin
        hx_e  = {1'b0, hx_q};
        hy_e  = {1'b0, hy_q};
        lx_e  = {1'b0, hold_x};
        ty_e  = {1'b0, hold_y};
        rx_e  = lx_e + W_EXT;
        by_e  = ty_e + H_EXT;
        match = hold_valid
              && (hx_e >= lx_e) && (hx_e < rx_e)
              && (hy_e >= ty_e) && (hy_e < by_e);
    end

    // Next fetch address, saturating on the last table entry.
    always_comb begin
        if (addr_q == LAST) begin
            addr_inc = LAST;
        end else begin
            addr_inc = addr_q + IDX_W'(1);
        end
    end

    // Next-state and result logic; k tracks the entry whose data is returned.
    always_comb begin
        state_d = state_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        addr_d  = addr_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hit_d   = hit_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                    hx_d    = hand_x;
                    hy_d    = hand_y;
                    addr_d  = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            PRIME: begin
                state_d = SCAN;
                addr_d  = addr_inc;
                k_d     = '0;
            end
            SCAN: begin
                if (match) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    idx_d   = k_q;
                    busy_d  = 1'b0;
                end else if (k_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    k_d    = k_q + IDX_W'(1);
                    addr_d = addr_inc;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any scan silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hx_q    <= '0;
            hy_q    <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    assign hold_addr = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hit       = hit_q;
    assign hit_index = idx_q;

endmodule

// File: tb/tb_hold_grab_detector.sv
// Bench for hold_grab_detector: directed edge cases plus random tables
// checked against a plain first-match search over the table contents.
module tb_hold_grab_detector;

    localparam int NH  = 16;
    localparam int IW  = 4;
    localparam int HW  = 32;
    localparam int HH  = 8;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [12:0]   hand_x;
    logic [12:0]   hand_y;
    logic [IW-1:0] hold_addr;
    logic [12:0]   hold_x;
    logic [12:0]   hold_y;
    logic          hold_valid;
    logic          busy;
    logic          done;
    logic          hit;
    logic [IW-1:0] hit_index;

    int tbl_x [NH];
    int tbl_y [NH];
    bit tbl_v [NH];

    int n_cmp;
    int n_bad;

    hold_grab_detector #(
        .NUM_HOLDS(NH),
        .IDX_W    (IW),
        .HOLD_W   (HW),
        .HOLD_H   (HH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .hand_x    (hand_x),
        .hand_y    (hand_y),
        .hold_addr (hold_addr),
        .hold_x    (hold_x),
        .hold_y    (hold_y),
        .hold_valid(hold_valid),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_index (hit_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read hold table
    always @(posedge clock) begin
        hold_x     <= 13'(tbl_x[hold_addr]);
        hold_y     <= 13'(tbl_y[hold_addr]);
        hold_valid <= tbl_v[hold_addr];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_hit(input int hx, input int hy);
        for (int i = 0; i < NH; i++) begin
            if (tbl_v[i] && hx >= tbl_x[i] && hx < tbl_x[i] + HW
                && hy >= tbl_y[i] && hy < tbl_y[i] + HH)
                return i;
        end
        return -1;
    endfunction

    function automatic int exp_lat(input int e);
        return (e >= 0) ? e + 2 : NH + 1;
    endfunction

    task automatic clear_tbl();
        for (int i = 0; i < NH; i++) begin
            tbl_x[i] = 0;
            tbl_y[i] = 0;
            tbl_v[i] = 1'b0;
        end
    endtask

    // One scan from idle; optional stray start and hand change mid-scan.
    task automatic do_scan(input string tag, input int hx, input int hy,
                           input bit poke_start, input bit poke_hand);
        int e;
        int lat;
        int n;
        bit got;
        e   = ref_hit(hx, hy);
        lat = exp_lat(e);
        hand_x = 13'(hx);
        hand_y = 13'(hy);
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        got = 1'b0;
        n = 0;
        while (!got && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (done) got = 1'b1;
            if (poke_start) start = (n == 1);
            if (poke_hand && n == 1) begin
                hand_x = ~hand_x;
                hand_y = ~hand_y;
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, got ? n : -1, lat);
        chk({tag, " hit"}, int'(hit), (e >= 0) ? 1 : 0);
        chk({tag, " hit_index"}, int'(hit_index), (e >= 0) ? e : 0);
        chk({tag, " busy@done"}, int'(busy), 0);
        @(posedge clock); #1;
        chk({tag, " done 1-cycle"}, int'(done), 0);
        chk({tag, " not queued"}, int'(busy), 0);
    endtask

    // start held high: two scans with no idle cycle between them.
    task automatic b2b(input string tag, input int hx, input int hy);
        int e;
        int lat;
        int n;
        e   = ref_hit(hx, hy);
        lat = exp_lat(e);
        hand_x = 13'(hx);
        hand_y = 13'(hy);
        start  = 1'b1;
        @(posedge clock); #1;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, " first lat"}, n, lat);
        @(posedge clock); #1;
        chk({tag, " restart busy"}, int'(busy), 1);
        chk({tag, " restart done"}, int'(done), 0);
        n = 0;
        while (!done && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, " second lat"}, n, lat);
        chk({tag, " second idx"}, int'(hit_index), (e >= 0) ? e : 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk({tag, " idle after"}, int'(busy), 0);
    endtask

    initial begin
        int hx;
        int hy;
        int dones;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        hand_x  = '0;
        hand_y  = '0;
        clear_tbl();
        repeat (3) @(posedge clock);
        #1;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst hit", int'(hit), 0);
        chk("rst idx", int'(hit_index), 0);
        chk("rst addr", int'(hold_addr), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // reset mid-scan
        tbl_x[5] = 300; tbl_y[5] = 40; tbl_v[5] = 1'b1;
        hand_x = 13'd310; hand_y = 13'd41; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #2;
        chk("abort busy", int'(busy), 0);
        chk("abort addr", int'(hold_addr), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            dones += int'(done);
        end
        chk("abort no done", dones, 0);
        chk("abort busy after", int'(busy), 0);
        chk("abort hit", int'(hit), 0);
        chk("abort idx", int'(hit_index), 0);
        do_scan("after reset", 310, 41, 1'b0, 1'b0);

        // corner and exclusive edges
        clear_tbl();
        tbl_x[3] = 100; tbl_y[3] = 200; tbl_v[3] = 1'b1;
        do_scan("corner", 100, 200, 1'b0, 1'b0);
        do_scan("right edge", 132, 207, 1'b0, 1'b0);
        do_scan("inside edge", 131, 207, 1'b0, 1'b0);
        do_scan("bottom edge", 131, 208, 1'b0, 1'b0);

        // priority and valid flag
        clear_tbl();
        tbl_v[2] = 1'b0;
        tbl_v[6] = 1'b1;
        do_scan("valid skip", 10, 4, 1'b0, 1'b0);
        tbl_v[2] = 1'b1;
        do_scan("priority", 10, 4, 1'b0, 1'b0);

        // no wrap near the world edge
        clear_tbl();
        tbl_x[0] = 8180; tbl_y[0] = 8190; tbl_v[0] = 1'b1;
        do_scan("no wrap", 8191, 8191, 1'b0, 1'b0);
        do_scan("wrap miss", 5, 5, 1'b0, 1'b0);

        // handshake
        clear_tbl();
        tbl_x[7] = 500; tbl_y[7] = 600; tbl_v[7] = 1'b1;
        do_scan("stray start", 510, 601, 1'b1, 1'b0);
        do_scan("hand change", 510, 601, 1'b0, 1'b1);
        b2b("b2b hit", 510, 601);
        b2b("b2b miss", 20, 20);

        // random tables with holds clustered around the hand
        for (int t = 0; t < 60; t++) begin
            hx = int'($urandom_range(0, 8191));
            hy = int'($urandom_range(0, 8191));
            for (int i = 0; i < NH; i++) begin
                tbl_v[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    tbl_x[i] = hx - int'($urandom_range(0, HW + 2));
                    tbl_y[i] = hy - int'($urandom_range(0, HH + 2));
                    if (tbl_x[i] < 0) tbl_x[i] = 0;
                    if (tbl_y[i] < 0) tbl_y[i] = 0;
                end else begin
                    tbl_x[i] = int'($urandom_range(0, 8191));
                    tbl_y[i] = int'($urandom_range(0, 8191));
                end
            end
            do_scan("random", hx, hy,
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hold_grab_detector.md
Name: hold_grab_detector

Overview:
- Inverse of the per-pixel hold renderer. The renderer asks "which pixel lies inside a hold"; this block asks "which hold contains this world point".
- On a start pulse it latches a hand position in world coordinates and scans the hold table one entry per clock. It reports the lowest-index hold whose rectangle contains the point.
- Sits between climber control logic and the hold-position table RAM, which the renderers also read. Climber control uses the result to decide whether a grab succeeds.

Parameters:
- NUM_HOLDS, 16, number of hold table entries scanned (2..2^IDX_W).
- IDX_W, 4, width of hold index and table address.
- HOLD_W, 32, hold rectangle width in world pixels.
- HOLD_H, 8, hold rectangle height in world pixels.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- hand_x  in  13  hand world x; latched when start is accepted.
- hand_y  in  13  hand world y; latched when start is accepted.
- hold_addr  out  IDX_W  hold table read address.
- hold_x  in  13  hold world x (left edge); valid one clock after hold_addr (synchronous RAM).
- hold_y  in  13  hold world y (top edge); same timing as hold_x.
- hold_valid  in  1  entry-in-use flag; same timing as hold_x.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the result is updated.
- hit  out  1  point lies inside a valid hold; held until the next done.
- hit_index  out  IDX_W  index of the hit hold; 0 on miss; held until the next done.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; busy=0, done=0, hit=0, hit_index=0, hold_addr=0, latched hand coordinates=0.
- Reset asserted mid-scan aborts the scan; no done is produced.
- States:
  - IDLE.
  - PRIME: first RAM read in flight.
  - SCAN: compare the returned entry while fetching the next one.
- Transitions:
  - IDLE --start=1--> PRIME. Latch hand_x/hand_y, hold_addr<=0, busy<=1.
  - PRIME --> SCAN. hold_addr<=1; clamp at NUM_HOLDS-1.
  - SCAN: the compare index k is a registered counter tracking the data currently returned.
    - Entry k matches: done<=1, hit<=1, hit_index<=k, busy<=0, go to IDLE.
    - No match and k==NUM_HOLDS-1: done<=1, hit<=0, hit_index<=0, busy<=0, go to IDLE.
    - Otherwise: k<=k+1; hold_addr<=min(hold_addr+1, NUM_HOLDS-1).
- Match rule:
  - hold_valid=1
  - AND hx>=hold_x AND hx<hold_x+HOLD_W
  - AND hy>=hold_y AND hy<hold_y+HOLD_H.
  - Sums are computed at 14 bits, so a hold near 8191 never wraps.
  - Edges: left/top edges inclusive, right/bottom edges exclusive (identical to the renderer).
- Latency: with start sampled at edge E0, a hit at index i gives done high for exactly the one cycle after edge E(i+2). A full miss gives done after edge E(NUM_HOLDS+1).
- Priority: the first (lowest-index) match wins; later entries are not read.
- start while busy is ignored and not queued. start in the same cycle as done is sampled in IDLE and accepted, so back-to-back scans have no dead cycle.
- hand_x/hand_y changes during a scan have no effect.
- hold table contents changing mid-scan: each entry is evaluated using the data returned for it; no consistency guarantee.
- done is never high for two consecutive cycles. busy and done are never both high.

Test Plan:
- Reset: hold reset_n=0 mid-scan (scan started with hit expected at index 5), release → busy=0, done never pulses, all outputs 0, next start scans normally.
- Hit on corner: hold 3 = (100,200,valid), hand=(100,200), holds 0-2 invalid → done 5 edges after start, hit=1, hit_index=3.
- Exclusive edge: hold 3 = (100,200), hand=(132,207) → hit=0, hit_index=0, done after edge E17. Repeat with hand=(131,207) → hit=1, hit_index=3.
- Priority and valid flag:
  - hold 2 = (0,0,valid=0) and hold 6 = (0,0,valid=1) overlap hand (10,4) → hit_index=6.
  - Set hold 2 valid=1 → hit_index=2.
- No wrap: hold 0 = (8180,8190), hand=(8191,8191) → hit=1, hit_index=0. Hand=(5,5) → miss.
- Handshake:
  - start held high continuously gives back-to-back done pulses with no idle gap.
  - A start pulse while busy is ignored.
  - hand_x changed mid-scan does not alter the result.
